// File: rtl/dvp_pxl_downscaler.sv
// dvp_pxl_downscaler: keeps 1 of every (h_skip+1) pixels and 1 of every
// (v_skip+1) lines of a DVP pixel stream. It regenerates SOF/EOL so they sit
// on kept pixels, and uses valid/ready flow control on both sides.
// A one-deep hold register (H) delays each kept pixel until the design knows
// whether that pixel closes its line.
module dvp_pxl_downscaler #(
   parameter int PXL_W       = 16,
   parameter int CONF_DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CONF_DATA_W-1:0] scaler_conf_i,
   input  logic                   dvp_en_i,
   input  logic [PXL_W-1:0]       bwd_pxl_i,
   input  logic                   bwd_sof_i,
   input  logic                   bwd_eol_i,
   input  logic                   bwd_vld_i,
   output logic                   bwd_rdy_o,
   output logic [PXL_W-1:0]       fwd_pxl_o,
   output logic                   fwd_sof_o,
   output logic                   fwd_eol_o,
   output logic                   fwd_vld_o,
   input  logic                   fwd_rdy_i
);

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

   state_t           state, state_next;
   logic [PXL_W-1:0] h_pxl;
   logic             h_sof, h_vld;
   logic [3:0]       h_cnt, v_cnt, h_skip, v_skip;
   logic [3:0]       conf_h, conf_v;
   logic             o_free, keep;
   logic             rdy, o_from_h, o_from_p, o_eol_val, o_sof_p;
   logic             h_load, h_sof_val, h_clr, restart, advance;
   logic             unused_conf;

   // With scale_en clear, the skip fields are treated as zero (bypass).
   assign conf_h      = scaler_conf_i[8] ? scaler_conf_i[3:0] : 4'd0;
   assign conf_v      = scaler_conf_i[8] ? scaler_conf_i[7:4] : 4'd0;
   assign unused_conf = ^scaler_conf_i[CONF_DATA_W-1:9];

   assign o_free    = ~fwd_vld_o | fwd_rdy_i;
   assign keep      = (h_cnt == 4'd0) && (v_cnt == 4'd0);
   assign bwd_rdy_o = rdy;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state, input ready, and datapath move decisions
   always_comb begin
      state_next = state;
      rdy        = 1'b0;
      o_from_h   = 1'b0;
      o_from_p   = 1'b0;
      o_eol_val  = 1'b0;
      o_sof_p    = 1'b0;
      h_load     = 1'b0;
      h_sof_val  = 1'b0;
      h_clr      = 1'b0;
      restart    = 1'b0;
      advance    = 1'b0;
      case (state)
         IDLE: begin
            rdy = 1'b1;
            if (bwd_vld_i && bwd_sof_i && dvp_en_i) begin
               restart    = 1'b1;
               state_next = ACTIVE;
               if (bwd_eol_i && o_free) begin
                  // One-pixel first line: it goes straight out.
                  o_from_p  = 1'b1;
                  o_eol_val = 1'b1;
                  o_sof_p   = 1'b1;
               end else begin
                  // O may still hold the previous frame's tail, so park in H.
                  h_load    = 1'b1;
                  h_sof_val = 1'b1;
                  if (bwd_eol_i) state_next = FLUSH;
               end
            end
         end
         ACTIVE: begin
            rdy = o_free;
            if (bwd_vld_i && o_free) begin
               if (bwd_sof_i) begin
                  // New frame start: close out any pending pixel of the old one.
                  if (h_vld) begin
                     o_from_h  = 1'b1;
                     o_eol_val = 1'b1;
                     h_clr     = 1'b1;
                  end
                  if (!dvp_en_i) begin
                     state_next = IDLE;
                  end else begin
                     restart = 1'b1;
                     if (bwd_eol_i && !h_vld) begin
                        o_from_p  = 1'b1;
                        o_eol_val = 1'b1;
                        o_sof_p   = 1'b1;
                     end else begin
                        h_load    = 1'b1;
                        h_sof_val = 1'b1;
                        if (bwd_eol_i) state_next = FLUSH;
                     end
                  end
               end else begin
                  advance = 1'b1;
                  if (keep) begin
                     if (bwd_eol_i && !h_vld) begin
                        o_from_p  = 1'b1;
                        o_eol_val = 1'b1;
                     end else begin
                        o_from_h = h_vld;
                        h_load   = 1'b1;
                        if (bwd_eol_i) state_next = FLUSH;
                     end
                  end else if (bwd_eol_i && h_vld) begin
                     // Dropped EOL: the held pixel is the last kept one of the line.
                     o_from_h  = 1'b1;
                     o_eol_val = 1'b1;
                     h_clr     = 1'b1;
                  end
               end
            end
         end
         FLUSH: begin
            if (o_free) begin
               o_from_h   = 1'b1;
               o_eol_val  = 1'b1;
               h_clr      = 1'b1;
               state_next = ACTIVE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Hold register H and output register O
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_pxl     <= '0;
         h_sof     <= 1'b0;
         h_vld     <= 1'b0;
         fwd_pxl_o <= '0;
         fwd_sof_o <= 1'b0;
         fwd_eol_o <= 1'b0;
         fwd_vld_o <= 1'b0;
      end else begin
         if (h_load) begin
            h_pxl <= bwd_pxl_i;
            h_sof <= h_sof_val;
            h_vld <= 1'b1;
         end else if (h_clr) begin
            h_vld <= 1'b0;
         end
         if (o_from_h) begin
            fwd_pxl_o <= h_pxl;
            fwd_sof_o <= h_sof;
            fwd_eol_o <= o_eol_val;
            fwd_vld_o <= 1'b1;
         end else if (o_from_p) begin
            fwd_pxl_o <= bwd_pxl_i;
            fwd_sof_o <= o_sof_p;
            fwd_eol_o <= o_eol_val;
            fwd_vld_o <= 1'b1;
         end else if (fwd_rdy_i) begin
            fwd_vld_o <= 1'b0;
         end
      end
   end

   // Decimation counters and shadow skip values, restarted on every SOF
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt  <= 4'd0;
         v_cnt  <= 4'd0;
         h_skip <= 4'd0;
         v_skip <= 4'd0;
      end else if (restart) begin
         // The SOF pixel itself is position (0,0); count it immediately.
         h_skip <= conf_h;
         v_skip <= conf_v;
         h_cnt  <= (bwd_eol_i || conf_h == 4'd0) ? 4'd0 : 4'd1;
         v_cnt  <= (bwd_eol_i && conf_v != 4'd0) ? 4'd1 : 4'd0;
      end else if (advance) begin
         if (bwd_eol_i) begin
            h_cnt <= 4'd0;
            v_cnt <= (v_cnt == v_skip) ? 4'd0 : v_cnt + 4'd1;
         end else begin
            h_cnt <= (h_cnt == h_skip) ? 4'd0 : h_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_dvp_pxl_downscaler.sv
// Testbench for dvp_pxl_downscaler. It drives directed and random frames and
// predicts each frame's output from row/column modulo rules into a scoreboard
// queue. An independent monitor pops that queue on each output handshake.
module tb_dvp_pxl_downscaler;
   localparam int PXL_W       = 16;
   localparam int CONF_DATA_W = 32;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [CONF_DATA_W-1:0] scaler_conf_i;
   logic                   dvp_en_i;
   logic [PXL_W-1:0]       bwd_pxl_i;
   logic                   bwd_sof_i, bwd_eol_i, bwd_vld_i, bwd_rdy_o;
   logic [PXL_W-1:0]       fwd_pxl_o;
   logic                   fwd_sof_o, fwd_eol_o, fwd_vld_o, fwd_rdy_i;

   int          n_vec = 0;
   int          n_err = 0;
   int          out_count = 0;
   int          rdy_mode = 0;
   logic [17:0] sb[$];
   logic        mon_hold = 1'b0;
   logic [17:0] mon_prev = '0;
   logic [17:0] mon_got, mon_exp;
   int          s, es, oc;

   dvp_pxl_downscaler #(.PXL_W(PXL_W), .CONF_DATA_W(CONF_DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .scaler_conf_i(scaler_conf_i), .dvp_en_i(dvp_en_i),
      .bwd_pxl_i(bwd_pxl_i), .bwd_sof_i(bwd_sof_i), .bwd_eol_i(bwd_eol_i),
      .bwd_vld_i(bwd_vld_i), .bwd_rdy_o(bwd_rdy_o),
      .fwd_pxl_o(fwd_pxl_o), .fwd_sof_o(fwd_sof_o), .fwd_eol_o(fwd_eol_o),
      .fwd_vld_o(fwd_vld_o), .fwd_rdy_i(fwd_rdy_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Output ready pattern: 0 always ready, 1 toggling, 2 random, 3 stalled.
   initial begin
      fwd_rdy_i = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       fwd_rdy_i = 1'b1;
            1:       fwd_rdy_i = ~fwd_rdy_i;
            2:       fwd_rdy_i = ($urandom_range(0, 99) < 60);
            default: fwd_rdy_i = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on each handshake and checks O stays held under stall.
   initial begin
      forever begin
         @(negedge clk);
         mon_got = {fwd_pxl_o, fwd_sof_o, fwd_eol_o};
         if (!rst_n) begin
            mon_hold = 1'b0;
         end else begin
            if (mon_hold) begin
               n_vec++;
               if (!fwd_vld_o || mon_got !== mon_prev) begin
                  n_err++;
                  $display("FAIL hold_stable: got vld=%b out=%h, required vld=1 out=%h",
                           fwd_vld_o, mon_got, mon_prev);
               end
            end
            if (fwd_vld_o && fwd_rdy_i) begin
               out_count++;
               n_vec++;
               if (sb.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_output: got pxl=%h sof=%b eol=%b, required none",
                           fwd_pxl_o, fwd_sof_o, fwd_eol_o);
               end else begin
                  mon_exp = sb.pop_front();
                  $display("out pxl=%h sof=%b eol=%b (expected pxl=%h sof=%b eol=%b)",
                           fwd_pxl_o, fwd_sof_o, fwd_eol_o, mon_exp[17:2], mon_exp[1], mon_exp[0]);
                  if (mon_got !== mon_exp) begin
                     n_err++;
                     $display("FAIL output: got pxl=%h sof=%b eol=%b, required pxl=%h sof=%b eol=%b",
                              fwd_pxl_o, fwd_sof_o, fwd_eol_o, mon_exp[17:2], mon_exp[1], mon_exp[0]);
                  end
               end
            end
            mon_hold = fwd_vld_o && !fwd_rdy_i;
            mon_prev = mon_got;
         end
      end
   end

   // Drive one beat after an idle gap; stalls counts cycles spent waiting on ready.
   task automatic send_beat(input logic [15:0] p, input logic sof, input logic eol,
                            input int gap, output int stalls);
      int   waited;
      logic r;
      stalls    = 0;
      waited    = 0;
      bwd_vld_i = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      bwd_pxl_i = p;
      bwd_sof_i = sof;
      bwd_eol_i = eol;
      bwd_vld_i = 1'b1;
      forever begin
         @(negedge clk);
         r = bwd_rdy_o;
         @(posedge clk); #1;
         if (r) break;
         stalls++;
         waited++;
         if (waited > 1000) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_accept: bwd_rdy_o low for %0d cycles, required accept", waited);
            break;
         end
      end
      bwd_vld_i = 1'b0;
   endtask

   // Build a frame, predict its output with modulo arithmetic, then drive it.
   // A trunc>0 adds a partial last line without EOL (ended by the next SOF).
   // The expected stall count covers only kept-EOL flushes that a following beat can observe.
   task automatic send_frame(input logic [31:0] conf, input logic en, input int nlines,
                             input int len, input int trunc, input logic seq, input int gap_max,
                             output int stalls, output int exp_stalls);
      logic [15:0] pix [0:63];
      int he, ve, rows, rl, last, st;
      he         = conf[8] ? int'(conf[3:0]) : 0;
      ve         = conf[8] ? int'(conf[7:4]) : 0;
      rows       = nlines + ((trunc > 0) ? 1 : 0);
      stalls     = 0;
      exp_stalls = 0;
      for (int r = 0; r < rows; r++) begin
         rl = (r < nlines) ? len : trunc;
         for (int c = 0; c < rl; c++)
            pix[r*8+c] = seq ? 16'(r*len + c) : 16'($urandom);
      end
      if (en) begin
         for (int r = 0; r < rows; r++) begin
            if (r % (ve + 1) == 0) begin
               rl   = (r < nlines) ? len : trunc;
               last = ((rl - 1) / (he + 1)) * (he + 1);
               for (int c = 0; c < rl; c += he + 1)
                  sb.push_back({pix[r*8+c], 1'(r == 0 && c == 0), 1'(c == last)});
               if (r < rows - 1 && r < nlines && last == rl - 1 && last > 0)
                  exp_stalls++;
            end
         end
      end
      dvp_en_i      = en;
      scaler_conf_i = conf;
      for (int r = 0; r < rows; r++) begin
         rl = (r < nlines) ? len : trunc;
         for (int c = 0; c < rl; c++) begin
            send_beat(pix[r*8+c], 1'(r == 0 && c == 0), 1'(r < nlines && c == rl - 1),
                      (gap_max > 0) ? $urandom_range(0, gap_max) : 0, st);
            stalls += st;
            // Mid-frame config and enable changes must have no effect.
            scaler_conf_i = $urandom;
            dvp_en_i      = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
      check("drain_pending", sb.size(), 0);
      sb.delete();
      repeat (5) begin @(posedge clk); #1; end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bwd_vld_i     = 1'b0;
      bwd_pxl_i     = '0;
      bwd_sof_i     = 1'b0;
      bwd_eol_i     = 1'b0;
      dvp_en_i      = 1'b0;
      scaler_conf_i = '0;
      #12;
      check("reset_fwd_vld", fwd_vld_o, 0);
      check("reset_fwd_sof", fwd_sof_o, 0);
      check("reset_fwd_eol", fwd_eol_o, 0);
      check("reset_fwd_pxl", fwd_pxl_o, 0);
      check("reset_bwd_rdy", bwd_rdy_o, 1);
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Bypass: scale_en=0 with nonzero skip fields that must be ignored.
      rdy_mode = 0;
      send_frame(32'h0000_0033, 1'b1, 2, 4, 0, 1'b1, 0, s, es);
      check("bypass_flush_stalls", s, es);
      wait_drain();
      // h_skip=1, v_skip=1 on a 4x4 frame.
      send_frame(32'h0000_0111, 1'b1, 4, 4, 0, 1'b1, 0, s, es);
      check("h1v1_stalls", s, es);
      wait_drain();
      // h_skip=2: each kept EOL pixel with H valid costs one FLUSH stall.
      send_frame(32'h0000_0102, 1'b1, 3, 4, 0, 1'b1, 0, s, es);
      check("h2_flush_stalls", s, es);
      wait_drain();
      // Backpressure: toggling ready, same expected sequence.
      rdy_mode = 1;
      send_frame(32'h0000_0111, 1'b1, 4, 4, 0, 1'b1, 0, s, es);
      wait_drain();
      rdy_mode = 0;
      // Truncated frame: SOF arrives at col2 of line 1.
      send_frame(32'h0000_0000, 1'b1, 1, 4, 2, 1'b1, 0, s, es);
      send_frame(32'h0000_0000, 1'b1, 1, 4, 0, 1'b1, 0, s, es);
      wait_drain();
      // Capture disabled at SOF: nothing may come out.
      oc = out_count;
      send_frame(32'h0000_0000, 1'b0, 2, 4, 0, 1'b1, 0, s, es);
      wait_drain();
      check("disabled_frame_outputs", out_count - oc, 0);

      // Reset mid-line while O holds a pixel.
      rdy_mode = 3;
      repeat (2) begin @(posedge clk); #1; end
      dvp_en_i      = 1'b1;
      scaler_conf_i = '0;
      send_beat(16'hA000, 1'b1, 1'b0, 0, s);
      send_beat(16'hA001, 1'b0, 1'b0, 0, s);
      check("pre_reset_fwd_vld", fwd_vld_o, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_fwd_vld", fwd_vld_o, 0);
      check("midreset_fwd_pxl", fwd_pxl_o, 0);
      check("midreset_bwd_rdy", bwd_rdy_o, 1);
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      oc = out_count;
      send_beat(16'hB000, 1'b0, 1'b0, 0, s);
      send_beat(16'hB001, 1'b0, 1'b1, 0, s);
      repeat (6) begin @(posedge clk); #1; end
      check("post_reset_no_output", out_count - oc, 0);

      // Random frames under random ready and input gaps.
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] conf;
         conf      = $urandom;
         conf[3:0] = 4'($urandom_range(0, 4));
         conf[7:4] = 4'($urandom_range(0, 3));
         send_frame(conf, 1'($urandom_range(0, 9) != 0), $urandom_range(1, 6),
                    $urandom_range(1, 8),
                    (i == 39 || $urandom_range(0, 4) != 0) ? 0 : $urandom_range(1, 8),
                    1'b0, 2, s, es);
      end
      wait_drain();
      rdy_mode = 0;
      repeat (10) begin @(posedge clk); #1; end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
